// File: rtl/icache_assoc_pkg.sv
// Shared constants and types for the set-associative instruction cache.
// Defaults describe a 2-way, 4-set cache with 16-byte lines and 32-bit memory beats.
package icache_assoc_pkg;

    localparam int PHY_LEN           = 20;
    localparam int INST_LEN          = 32;
    localparam int ICACHE_WAYS       = 2;
    localparam int ICACHE_SETS       = 4;
    localparam int ICACHE_LINE_BYTES = 16;
    localparam int ICACHE_MEM_W      = 32;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REQ,
        IC_REFILL
    } icache_state_t;

    // Index width that never collapses to zero, so 1-entry selectors stay legal.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_plru.sv
// Per-set tree-PLRU state for 1, 2 or 4 ways. Bits point away from the most recently
// touched way; the victim is found by following the bits from the root.
module icache_assoc_plru
    import icache_assoc_pkg::*;
#(
    parameter int NUM_WAYS = ICACHE_WAYS,
    parameter int NUM_SETS = ICACHE_SETS,
    localparam int IDX_W   = clog2_min1(NUM_SETS),
    localparam int WAY_W   = clog2_min1(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hit_en,
    input  logic [IDX_W-1:0] hit_set,
    input  logic [WAY_W-1:0] hit_way,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_set,
    input  logic [WAY_W-1:0] fill_way,
    input  logic [IDX_W-1:0] victim_set,
    output logic [WAY_W-1:0] victim_way
);

    localparam int PB = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    logic [PB-1:0] bits_reg  [NUM_SETS];
    logic [PB-1:0] bits_next [NUM_SETS];

    // Bit 0 is the root (0 = lower half); bits 1/2 select within the lower/upper pair.
    function automatic logic [PB-1:0] touch(input logic [PB-1:0] b, input logic [WAY_W-1:0] w);
        logic [2:0] t;
        logic [1:0] ww;
        t  = 3'(b);
        ww = 2'(w);
        if (NUM_WAYS == 4) begin
            t[0] = ~ww[1];
            if (ww[1]) t[2] = ~ww[0];
            else       t[1] = ~ww[0];
        end else if (NUM_WAYS == 2) begin
            t[0] = ~ww[0];
        end
        return PB'(t);
    endfunction

    // A hit and a fill may touch the same set in one cycle; the fill is applied last.
    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
            always_comb begin
                bits_next[gi] = bits_reg[gi];
                if (hit_en && hit_set == IDX_W'(gi))
                    bits_next[gi] = touch(bits_next[gi], hit_way);
                if (fill_en && fill_set == IDX_W'(gi))
                    bits_next[gi] = touch(bits_next[gi], fill_way);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) bits_reg[s] <= '0;
        end else if (clear) begin
            for (int s = 0; s < NUM_SETS; s++) bits_reg[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_SETS; s++) bits_reg[s] <= bits_next[s];
        end
    end

    always_comb begin
        logic [2:0] t;
        logic [1:0] v;
        t = 3'(bits_reg[victim_set]);
        v = 2'b00;
        if (NUM_WAYS == 4)      v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
        else if (NUM_WAYS == 2) v = {1'b0, t[0]};
        victim_way = WAY_W'(v);
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: zero-latency tag lookup, multi-beat line refill
// into a victim way chosen by invalid-first then tree-PLRU, and whole-cache flush.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int NUM_WAYS   = ICACHE_WAYS,
    parameter int NUM_SETS   = ICACHE_SETS,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES,
    parameter int MEM_DATA_W = ICACHE_MEM_W,
    parameter int ADDR_W     = PHY_LEN,
    parameter int INST_W     = INST_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  enable,
    input  logic                  flush,
    output logic [INST_W-1:0]     instr_data,
    output logic                  miss,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = clog2_min1(NUM_SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / MEM_DATA_W;
    localparam int CNT_W  = clog2_min1(BEATS);
    localparam int WORDS  = LINE_W / INST_W;
    localparam int WS_W   = clog2_min1(WORDS);
    localparam int WAY_W  = clog2_min1(NUM_WAYS);

    logic [LINE_W-1:0]     data_mem [NUM_WAYS][NUM_SETS];
    logic [TAG_W-1:0]      tag_mem  [NUM_WAYS][NUM_SETS];
    logic [NUM_SETS-1:0]   valid_reg [NUM_WAYS];
    logic [MEM_DATA_W-1:0] fill_buf [BEATS];
    logic [LINE_W-1:0]     fill_line;

    icache_state_t    state_reg, state_next;
    logic [ADDR_W-1:0] line_addr_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic              discard_reg;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [WS_W-1:0]     word_sel;
    logic [NUM_WAYS-1:0] way_hit;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [LINE_W-1:0]   hit_line;
    logic [INST_W-1:0]   hit_words [WORDS];
    logic [WAY_W-1:0]    plru_victim;
    logic [WAY_W-1:0]    victim;
    logic [IDX_W-1:0]    line_idx;
    logic [TAG_W-1:0]    line_tag;
    logic                last_beat;
    logic                install;
    logic                unused_bits;

    assign idx         = addr[OFF_W +: IDX_W];
    assign tag         = addr[ADDR_W-1 -: TAG_W];
    assign line_idx    = line_addr_reg[OFF_W +: IDX_W];
    assign line_tag    = line_addr_reg[ADDR_W-1 -: TAG_W];
    assign unused_bits = ^addr[1:0];

    generate
        if (OFF_W > 2) begin : g_wsel
            assign word_sel = WS_W'(addr[OFF_W-1:2]);
        end else begin : g_wsel_one
            assign word_sel = '0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_hit[gi] = valid_reg[gi][idx] && (tag_mem[gi][idx] == tag);
        end
    endgenerate

    // Fills never create duplicates, so at most one way can match.
    always_comb begin
        hit_line = '0;
        hit_way  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_hit[w]) begin
                hit_line = data_mem[w][idx];
                hit_way  = WAY_W'(w);
            end
        end
    end

    assign hit = |way_hit;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign hit_words[gi] = hit_line[gi*INST_W +: INST_W];
        end
    endgenerate

    assign miss       = enable && !hit;
    assign instr_data = (enable && hit) ? hit_words[word_sel] : '0;

    // Lowest-index invalid way first; PLRU only decides once the set is full.
    always_comb begin
        victim = plru_victim;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[w][idx]) victim = WAY_W'(w);
        end
    end

    icache_assoc_plru #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) u_plru (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .hit_en     (enable && hit),
        .hit_set    (idx),
        .hit_way    (hit_way),
        .fill_en    (install),
        .fill_set   (line_idx),
        .fill_way   (victim_reg),
        .victim_set (idx),
        .victim_way (plru_victim)
    );

    assign last_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        install    = 1'b0;
        case (state_reg)
            IC_IDLE: begin
                if (enable && !hit && !flush) state_next = IC_REQ;
            end
            IC_REQ: begin
                mem_req = 1'b1;
                if (mem_ready) state_next = IC_REFILL;
            end
            IC_REFILL: begin
                if (mem_rvalid && last_beat) begin
                    state_next = IC_IDLE;
                    install    = !flush && !discard_reg;
                end
            end
            default: state_next = IC_IDLE;
        endcase
    end

    assign mem_addr = line_addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IC_IDLE;
            line_addr_reg <= '0;
            victim_reg    <= '0;
            beat_cnt_reg  <= '0;
            discard_reg   <= 1'b0;
            for (int w = 0; w < NUM_WAYS; w++) valid_reg[w] <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IC_IDLE && state_next == IC_REQ) begin
                line_addr_reg <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                victim_reg    <= victim;
            end
            if (state_reg == IC_REQ && mem_ready)
                beat_cnt_reg <= '0;
            else if (state_reg == IC_REFILL && mem_rvalid)
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            // A flushed refill still drains its beats but must never be installed.
            if (state_next == IC_IDLE)
                discard_reg <= 1'b0;
            else if (flush)
                discard_reg <= 1'b1;
            if (flush) begin
                for (int w = 0; w < NUM_WAYS; w++) valid_reg[w] <= '0;
            end else if (install) begin
                valid_reg[victim_reg][line_idx] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_fill
            if (gi == BEATS - 1) begin : g_last
                assign fill_line[gi*MEM_DATA_W +: MEM_DATA_W] = mem_rdata;
            end else begin : g_buf
                assign fill_line[gi*MEM_DATA_W +: MEM_DATA_W] = fill_buf[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (state_reg == IC_REFILL && mem_rvalid)
            fill_buf[beat_cnt_reg] <= mem_rdata;
        if (install) begin
            data_mem[victim_reg][line_idx] <= fill_line;
            tag_mem[victim_reg][line_idx]  <= line_tag;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (default parameters) with a line-level reference model
// checked every cycle plus hand-computed literal expectations.
module tb_icache_assoc;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] addr = '0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_data;
    logic        miss;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    icache_assoc dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .enable     (enable),
        .flush      (flush),
        .instr_data (instr_data),
        .miss       (miss),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which line lives in which way, plus the way to evict when the set is full.
    bit          m_valid [2][4];
    logic [13:0] m_tag   [2][4];
    logic [31:0] m_data  [2][4][4];
    int          m_evict [4];
    bit          m_busy, m_acc, m_disc;
    int          m_n, m_vict;
    logic [19:0] m_line;
    logic [31:0] m_buf [4];

    function automatic int m_lookup(input logic [19:0] a);
        int s;
        s = int'(a[5:4]);
        for (int w = 0; w < 2; w++)
            if (m_valid[w][s] && m_tag[w][s] == a[19:6]) return w;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int s, hw, fs;
        if (rst) begin
            for (int w = 0; w < 2; w++) for (int i = 0; i < 4; i++) m_valid[w][i] = 0;
            for (int i = 0; i < 4; i++) m_evict[i] = 0;
            m_busy = 0; m_acc = 0; m_disc = 0; m_n = 0; m_line = '0;
        end else begin
            s  = int'(addr[5:4]);
            hw = m_lookup(addr);
            if (enable && hw >= 0) m_evict[s] = 1 - hw;
            if (m_busy) begin
                if (!m_acc) begin
                    if (mem_ready) begin m_acc = 1; m_n = 0; end
                end else if (mem_rvalid) begin
                    m_buf[m_n] = mem_rdata;
                    m_n++;
                    if (m_n == BEATS) begin
                        if (!flush && !m_disc) begin
                            fs = int'(m_line[5:4]);
                            m_valid[m_vict][fs] = 1;
                            m_tag[m_vict][fs]   = m_line[19:6];
                            for (int k = 0; k < 4; k++) m_data[m_vict][fs][k] = m_buf[k];
                            m_evict[fs] = 1 - m_vict;
                        end
                        m_busy = 0;
                        m_disc = 0;
                    end
                end
                if (flush && m_busy) m_disc = 1;
            end else if (!flush && enable && hw < 0) begin
                m_busy = 1;
                m_acc  = 0;
                m_line = {addr[19:4], 4'h0};
                m_vict = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : m_evict[s]);
            end
            if (flush) begin
                for (int w = 0; w < 2; w++) for (int i = 0; i < 4; i++) m_valid[w][i] = 0;
                for (int i = 0; i < 4; i++) m_evict[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        int hw;
        logic [31:0] exp_instr;
        if (run_cmp && !rst) begin
            hw = m_lookup(addr);
            exp_instr = (enable && hw >= 0) ? m_data[hw][int'(addr[5:4])][int'(addr[3:2])] : 32'h0;
            chk("model_miss", 32'(miss), 32'(enable && hw < 0));
            chk("model_instr", instr_data, exp_instr);
            chk("model_mem_req", 32'(mem_req), 32'(m_busy && !m_acc));
            if (m_busy && !m_acc) chk("model_mem_addr", 32'(mem_addr), 32'(m_line));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Miss on a, accept at once, then one beat per cycle; returns in the first hit cycle.
    task automatic do_fill(input logic [19:0] a, input logic [31:0] d0, input string name);
        addr = a; enable = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b0;
        @(negedge clk);
        chk(name, 32'(miss), 32'd1);
        cycle();
        cycle();
        for (int k = 0; k < BEATS; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = d0 + 32'(k);
            cycle();
        end
        mem_rvalid = 1'b0;
        $display("txn fill addr=%05h data0=%08h", a, d0);
    endtask

    initial begin
        bit [6:0] pat;
        int k;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run_cmp = 1'b1;
        @(negedge clk);
        chk("reset_instr", instr_data, 32'h0);
        chk("reset_miss", 32'(miss), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        cycle();

        // Cold miss with exact latency
        enable = 1'b1; addr = 20'h00010; mem_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            mem_rvalid = (c >= 2 && c <= 5);
            mem_rdata  = 32'hA0 + 32'(c - 2);
            @(negedge clk);
            if (c <= 5) chk("t1_miss", 32'(miss), 32'd1);
            else begin
                chk("t1_hit", 32'(miss), 32'd0);
                chk("t1_word0", instr_data, 32'hA0);
            end
            if (c == 1) begin
                chk("t1_req", 32'(mem_req), 32'd1);
                chk("t1_mem_addr", 32'(mem_addr), 32'h00010);
            end
            cycle();
        end
        mem_rvalid = 1'b0;
        addr = 20'h0001C;
        @(negedge clk);
        chk("t1_word3", instr_data, 32'hA3);
        $display("txn cold miss 00010 done");
        cycle();

        // Conflict and PLRU
        do_fill(20'h00050, 32'hC0, "t2_second_way_miss");
        addr = 20'h00010;
        @(negedge clk);
        chk("t2_touch_way0", instr_data, 32'hA0);
        cycle();
        do_fill(20'h00090, 32'hD0, "t2_conflict_miss");
        addr = 20'h00010;
        @(negedge clk);
        chk("t2_survivor_hit", 32'(miss), 32'd0);
        chk("t2_survivor_data", instr_data, 32'hA0);
        cycle();
        do_fill(20'h00050, 32'hC0, "t2_evicted_miss");
        $display("txn plru conflict done");

        // Backpressure and gapped beats
        addr = 20'h00210; enable = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("t3_miss", 32'(miss), 32'd1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_req_held", 32'(mem_req), 32'd1);
            chk("t3_addr_stable", 32'(mem_addr), 32'h00210);
            cycle();
        end
        mem_ready = 1'b1;
        cycle();
        pat = 7'b1100101;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            mem_rvalid = pat[i];
            mem_rdata  = pat[i] ? 32'hE0 + 32'(k) : 32'hDEAD;
            @(negedge clk);
            chk("t3_no_early_hit", 32'(miss), 32'd1);
            if (pat[i]) k++;
            cycle();
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t3_hit_word0", instr_data, 32'hE0);
        cycle();
        addr = 20'h0021C;
        @(negedge clk);
        chk("t3_hit_word3", instr_data, 32'hE3);
        cycle();
        $display("txn backpressure done");

        // Flush in IDLE, then flush in the middle of a refill
        do_fill(20'h00020, 32'hF0, "t4_fill_miss");
        @(negedge clk);
        chk("t4_filled", instr_data, 32'hF0);
        cycle();
        enable = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0; enable = 1'b1;
        @(negedge clk);
        chk("t4_flushed_miss", 32'(miss), 32'd1);
        cycle();
        cycle();
        for (int b = 0; b < BEATS; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h70 + 32'(b);
            flush      = (b == 1);
            cycle();
        end
        mem_rvalid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("t4_not_installed", 32'(miss), 32'd1);
        chk("t4_idle_after_drain", 32'(mem_req), 32'd0);
        cycle();
        @(negedge clk);
        chk("t4_new_request", 32'(mem_req), 32'd1);
        cycle();
        for (int b = 0; b < BEATS; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h80 + 32'(b);
            cycle();
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t4_refilled", instr_data, 32'h80);
        cycle();
        $display("txn flush done");

        // Asynchronous reset during refill
        addr = 20'h00030; enable = 1'b1;
        @(negedge clk);
        chk("t5_miss", 32'(miss), 32'd1);
        cycle();
        cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        cycle();
        mem_rdata = 32'h56;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_req", 32'(mem_req), 32'd0);
        chk("t5_async_miss", 32'(miss), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk("t5_stray_beat", 32'(mem_req), 32'd0);
        cycle();
        mem_rvalid = 1'b0;
        do_fill(20'h00010, 32'h60, "t5_cold_after_reset");
        $display("txn async reset done");

        // Redirect while refilling
        addr = 20'h00040; enable = 1'b1;
        @(negedge clk);
        chk("t6_miss", 32'(miss), 32'd1);
        cycle();
        cycle();
        for (int b = 0; b < BEATS; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h90 + 32'(b);
            if (b == 1) addr = 20'h00100;
            cycle();
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_new_miss", 32'(miss), 32'd1);
        chk("t6_idle", 32'(mem_req), 32'd0);
        cycle();
        @(negedge clk);
        chk("t6_req", 32'(mem_req), 32'd1);
        chk("t6_req_addr", 32'(mem_addr), 32'h00100);
        cycle();
        for (int b = 0; b < BEATS; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hB0 + 32'(b);
            cycle();
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_new_hit", instr_data, 32'hB0);
        cycle();
        addr = 20'h00044;
        @(negedge clk);
        chk("t6_latched_line", instr_data, 32'h91);
        cycle();
        $display("txn redirect done");

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
